// File: rtl/idex_hazard_ctrl.sv
// Load-use, HI/LO mult/div and taken-branch hazard control for the PC, IF/ID and ID/EX registers.
// Optional statistics counters are built when IDEX_HAZARD_STATS_EN is defined.
module idex_hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned STAT_W     = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [4:0]        IFID_Rs,
  input  logic [4:0]        IFID_Rt,
  input  logic              IFID_UsesRt,
  input  logic              IFID_HILOAccess,
  input  logic              IDEX_MemRead,
  input  logic [4:0]        IDEX_Rt,
  input  logic              EX_MDStart,
  input  logic              EX_BranchTaken,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              IFIDFlush,
  output logic              IDEXFlush,
  output logic              MDBusy,
  output logic              MDDone,
  output logic              MDOverlapErr,
  output logic [STAT_W-1:0] LoadStallCount,
  output logic [STAT_W-1:0] MDStallCount,
  output logic [STAT_W-1:0] FlushCount
);

  localparam int unsigned CNT_W = $clog2(MD_LATENCY + 1);
  localparam logic [CNT_W-1:0] MD_LAT = CNT_W'(MD_LATENCY);

  typedef enum logic {MdIdle, MdBusy} md_state_e;

  md_state_e        r_state, w_state_next;
  logic [CNT_W-1:0] r_md_count, w_md_count_next;
  logic             r_md_done, w_md_done_next;
  logic             r_overlap_err, w_overlap_err_next;
  logic             w_load_use, w_md_haz;
  logic             w_stall_lu, w_stall_md;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state       <= MdIdle;
      r_md_count    <= '0;
      r_md_done     <= 1'b0;
      r_overlap_err <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_md_count    <= w_md_count_next;
      r_md_done     <= w_md_done_next;
      r_overlap_err <= w_overlap_err_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_md_count_next    = r_md_count;
    w_md_done_next     = 1'b0;
    w_overlap_err_next = r_overlap_err;
    if (EX_MDStart) begin
      w_md_count_next = MD_LAT;
      w_state_next    = MdBusy;
      if (r_state == MdBusy) w_overlap_err_next = 1'b1;
    end else if (r_state == MdBusy) begin
      w_md_count_next = r_md_count - CNT_W'(1);
      if (r_md_count == CNT_W'(1)) begin
        w_state_next   = MdIdle;
        w_md_done_next = 1'b1;
      end
    end
  end

  assign MDBusy       = (r_state == MdBusy);
  assign MDDone       = r_md_done;
  assign MDOverlapErr = r_overlap_err;

  assign w_load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                      ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
  assign w_md_haz   = MDBusy && IFID_HILOAccess;

  // A taken branch discards the ID instruction, so its hazards never stall.
  assign w_stall_lu = !EX_BranchTaken && w_load_use;
  assign w_stall_md = !EX_BranchTaken && !w_load_use && w_md_haz;

  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    if (!Rst_n) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (EX_BranchTaken) begin
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (w_stall_lu || w_stall_md) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXFlush = 1'b1;
    end
  end

`ifdef IDEX_HAZARD_STATS_EN
  logic [STAT_W-1:0] r_lu_cnt, r_md_cnt, r_fl_cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_lu_cnt <= '0;
      r_md_cnt <= '0;
      r_fl_cnt <= '0;
    end else begin
      if (w_stall_lu && (r_lu_cnt != '1)) r_lu_cnt <= r_lu_cnt + STAT_W'(1);
      if (w_stall_md && (r_md_cnt != '1)) r_md_cnt <= r_md_cnt + STAT_W'(1);
      if (EX_BranchTaken && (r_fl_cnt != '1)) r_fl_cnt <= r_fl_cnt + STAT_W'(1);
    end
  end

  assign LoadStallCount = r_lu_cnt;
  assign MDStallCount   = r_md_cnt;
  assign FlushCount     = r_fl_cnt;
`else
  assign LoadStallCount = '0;
  assign MDStallCount   = '0;
  assign FlushCount     = '0;
`endif

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Randomized and directed bench for idex_hazard_ctrl against a behavioural pipeline model.
module tb_idex_hazard_ctrl;

  localparam int LAT    = 4;
  localparam int STAT_W = 2;
  localparam int SATV   = 3;

  logic Clk = 1'b0;
  logic Rst_n;
  logic [4:0] IFID_Rs, IFID_Rt, IDEX_Rt;
  logic IFID_UsesRt, IFID_HILOAccess, IDEX_MemRead, EX_MDStart, EX_BranchTaken;
  logic PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MDBusy, MDDone, MDOverlapErr;
  logic [STAT_W-1:0] LoadStallCount, MDStallCount, FlushCount;

  int n_checks = 0;
  int n_errors = 0;

  // Model: cycles left until HI/LO valid, done pulse, sticky overlap, event tallies.
  int m_cnt, m_lu, m_md, m_fl;
  bit m_done, m_err;

  always #5 Clk = ~Clk;

  idex_hazard_ctrl #(.MD_LATENCY(LAT), .STAT_W(STAT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .IFID_UsesRt(IFID_UsesRt), .IFID_HILOAccess(IFID_HILOAccess),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt), .EX_MDStart(EX_MDStart),
    .EX_BranchTaken(EX_BranchTaken), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .MDBusy(MDBusy), .MDDone(MDDone),
    .MDOverlapErr(MDOverlapErr), .LoadStallCount(LoadStallCount),
    .MDStallCount(MDStallCount), .FlushCount(FlushCount)
  );

  wire [6:0] got = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MDBusy, MDDone, MDOverlapErr};
  wire [5:0] got_stats = {LoadStallCount, MDStallCount, FlushCount};

  function automatic bit lu_now();
    return IDEX_MemRead && IDEX_Rt != 0 &&
           (IDEX_Rt == IFID_Rs || (IFID_UsesRt && IDEX_Rt == IFID_Rt));
  endfunction

  function automatic bit mdhaz_now();
    return (m_cnt > 0) && IFID_HILOAccess;
  endfunction

  function automatic logic [6:0] exp_vec();
    logic [3:0] ctl;
    if (!Rst_n) return 7'b0011000;
    if (EX_BranchTaken) ctl = 4'b1111;
    else if (lu_now() || mdhaz_now()) ctl = 4'b0001;
    else ctl = 4'b1100;
    return {ctl, m_cnt > 0, m_done, m_err};
  endfunction

  function automatic logic [1:0] sat(input int x);
    return (x > SATV) ? 2'd3 : 2'(x);
  endfunction

  function automatic logic [5:0] exp_stats();
`ifdef IDEX_HAZARD_STATS_EN
    return {sat(m_lu), sat(m_md), sat(m_fl)};
`else
    return 6'd0;
`endif
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_done = 0; m_err = 0; m_lu = 0; m_md = 0; m_fl = 0;
  endtask

  // Advance one clock, updating the model from the inputs held across the edge.
  task automatic tick();
    bit lu, mh;
    @(posedge Clk);
    if (!Rst_n) begin
      model_reset();
    end else begin
      lu = lu_now();
      mh = mdhaz_now();
      if (EX_BranchTaken) m_fl++;
      else if (lu) m_lu++;
      else if (mh) m_md++;
      m_done = (m_cnt == 1) && !EX_MDStart;
      if (EX_MDStart) begin
        if (m_cnt > 0) m_err = 1;
        m_cnt = LAT;
      end else if (m_cnt > 0) begin
        m_cnt--;
      end
    end
    #1;
  endtask

  task automatic idle();
    IFID_Rs = 0; IFID_Rt = 0; IDEX_Rt = 0; IFID_UsesRt = 0; IFID_HILOAccess = 0;
    IDEX_MemRead = 0; EX_MDStart = 0; EX_BranchTaken = 0;
  endtask

  task automatic test_reset();
    Rst_n = 0;
    idle();
    IDEX_MemRead = 1; IDEX_Rt = 8; IFID_Rs = 8; EX_BranchTaken = 1;
    model_reset();
    #3;
    n_checks++;
    if (got !== 7'b0011000) begin
      n_errors++; $display("FAIL reset_outputs got=%b want=%b", got, 7'b0011000);
    end
    n_checks++;
    if (got_stats !== 6'd0) begin
      n_errors++; $display("FAIL reset_stats got=%b want=0", got_stats);
    end
    tick();
    idle();
    Rst_n = 1;
    #2;
    n_checks++;
    if (got !== 7'b1100000) begin
      n_errors++; $display("FAIL after_reset got=%b want=%b", got, 7'b1100000);
    end
  endtask

  task automatic test_load_use();
    tick();
    idle(); IDEX_MemRead = 1; IDEX_Rt = 8; IFID_Rs = 8;
    #2;
    n_checks++;
    if (got !== exp_vec() || {PCWrite, IFIDWrite, IDEXFlush} !== 3'b001) begin
      n_errors++; $display("FAIL load_use_stall got=%b want=%b", got, exp_vec());
    end
    tick();
    IDEX_MemRead = 0;
    #2;
    n_checks++;
    if (got !== exp_vec() || {PCWrite, IFIDWrite, IDEXFlush} !== 3'b110) begin
      n_errors++; $display("FAIL load_use_release got=%b want=%b", got, exp_vec());
    end
    tick();
    IDEX_MemRead = 1; IDEX_Rt = 0; IFID_Rs = 0;
    #2;
    n_checks++;
    if (got !== exp_vec() || PCWrite !== 1'b1) begin
      n_errors++; $display("FAIL load_r0_nostall got=%b want=%b", got, exp_vec());
    end
  endtask

  task automatic test_rt_gating();
    tick();
    idle(); IDEX_MemRead = 1; IDEX_Rt = 9; IFID_Rt = 9; IFID_Rs = 3; IFID_UsesRt = 0;
    #2;
    n_checks++;
    if (got !== exp_vec() || PCWrite !== 1'b1) begin
      n_errors++; $display("FAIL rt_unused_nostall got=%b want=%b", got, exp_vec());
    end
    IFID_UsesRt = 1;
    #1;
    n_checks++;
    if (got !== exp_vec() || {PCWrite, IDEXFlush} !== 2'b01) begin
      n_errors++; $display("FAIL rt_used_stall got=%b want=%b", got, exp_vec());
    end
  endtask

  task automatic test_md_stall();
    tick();
    idle(); EX_MDStart = 1; IFID_HILOAccess = 1;
    #2;
    n_checks++;
    if (got !== exp_vec() || PCWrite !== 1'b1) begin
      n_errors++; $display("FAIL md_cycle0 got=%b want=%b", got, exp_vec());
    end
    for (int c = 1; c <= LAT; c++) begin
      tick();
      EX_MDStart = 0;
      #2;
      n_checks++;
      if (got !== exp_vec() || {PCWrite, MDBusy, MDDone} !== 3'b010) begin
        n_errors++; $display("FAIL md_stall_c%0d got=%b want=%b", c, got, exp_vec());
      end
    end
    tick();
    #2;
    n_checks++;
    if (got !== exp_vec() || {PCWrite, MDBusy, MDDone} !== 3'b101) begin
      n_errors++; $display("FAIL md_issue got=%b want=%b", got, exp_vec());
    end
  endtask

  task automatic test_branch_priority();
    tick();
    idle(); IDEX_MemRead = 1; IDEX_Rt = 5; IFID_Rs = 5; EX_BranchTaken = 1;
    #2;
    n_checks++;
    if (got !== exp_vec() || got[6:3] !== 4'b1111) begin
      n_errors++; $display("FAIL branch_over_loaduse got=%b want=%b", got, exp_vec());
    end
  endtask

  task automatic test_overlap_reset();
    tick();
    idle(); EX_MDStart = 1;
    tick();
    EX_MDStart = 0;
    tick();
    EX_MDStart = 1;
    tick();
    EX_MDStart = 0; IFID_HILOAccess = 1;
    #2;
    n_checks++;
    if (got !== exp_vec() || {MDBusy, MDOverlapErr} !== 2'b11) begin
      n_errors++; $display("FAIL overlap_err got=%b want=%b", got, exp_vec());
    end
    // Reload to full latency: busy must persist LAT-1 more cycles after this one.
    for (int c = 0; c < LAT - 1; c++) tick();
    #2;
    n_checks++;
    if (got !== exp_vec() || MDBusy !== 1'b1) begin
      n_errors++; $display("FAIL overlap_reload got=%b want=%b", got, exp_vec());
    end
    tick();
    EX_MDStart = 1;
    tick();
    EX_MDStart = 0;
    Rst_n = 0;
    model_reset();
    #1;
    n_checks++;
    if (got !== 7'b0011000) begin
      n_errors++; $display("FAIL midcount_reset got=%b want=%b", got, 7'b0011000);
    end
    tick();
    Rst_n = 1;
    idle();
    #2;
    n_checks++;
    if (got !== exp_vec() || {MDBusy, MDOverlapErr} !== 2'b00) begin
      n_errors++; $display("FAIL post_reset_clear got=%b want=%b", got, exp_vec());
    end
  endtask

  task automatic test_flush_sat();
    for (int i = 0; i < 4; i++) begin
      tick();
      idle(); EX_BranchTaken = 1;
    end
    tick();
    idle();
    #2;
    n_checks++;
    if (got_stats !== exp_stats()) begin
      n_errors++; $display("FAIL flush_stats got=%b want=%b", got_stats, exp_stats());
    end
`ifdef IDEX_HAZARD_STATS_EN
    n_checks++;
    if (FlushCount !== 2'd3) begin
      n_errors++; $display("FAIL flush_saturate got=%0d want=3", FlushCount);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick();
      IFID_Rs         = 5'($urandom_range(0, 3));
      IFID_Rt         = 5'($urandom_range(0, 3));
      IDEX_Rt         = 5'($urandom_range(0, 3));
      IFID_UsesRt     = 1'($urandom_range(0, 1));
      IFID_HILOAccess = 1'($urandom_range(0, 1));
      IDEX_MemRead    = ($urandom_range(0, 99) < 40);
      EX_MDStart      = ($urandom_range(0, 99) < 10);
      EX_BranchTaken  = ($urandom_range(0, 99) < 12);
      #2;
      n_checks++;
      if (got !== exp_vec() || got_stats !== exp_stats()) begin
        n_errors++;
        $display("FAIL random_%0d got=%b/%b want=%b/%b", i, got, got_stats, exp_vec(),
                 exp_stats());
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rt_gating();
    test_md_stall();
    test_branch_priority();
    test_overlap_reset();
    test_flush_sat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/idex_hazard_ctrl.md
Name: idex_hazard_ctrl

Overview:
Hazard and sequencing controller for the IF/ID and ID/EX pipeline registers and the PC.
- Detects load-use hazards and inserts one bubble into ID/EX.
- Flushes IF/ID and ID/EX when a branch or jump resolves taken in EX.
- Tracks the multi-cycle HI/LO mult/div unit with a busy counter and holds any dependent HI/LO instruction in ID until the result is ready.
- Sits beside the decode stage; its stall and flush outputs drive the PC write enable, the IF/ID write enable and flush, and the ID/EX flush input.

Parameters:
MD_LATENCY, 4, cycles from mult/div entering EX until HI/LO are valid; must be >= 1.
STAT_W, 16, width of the statistics counters (optional feature only).

Ports:
Clk  in  1  clock; all state updates on the rising edge.
Rst_n  in  1  asynchronous active-low reset.
IFID_Rs  in  5  rs field of the instruction in ID.
IFID_Rt  in  5  rt field of the instruction in ID.
IFID_UsesRt  in  1  the ID instruction reads rt as a source.
IFID_HILOAccess  in  1  the ID instruction is mfhi/mflo/mthi/mtlo/mult/multu/div/divu/madd/msub.
IDEX_MemRead  in  1  the instruction in EX is a load.
IDEX_Rt  in  5  destination rt of the instruction in EX.
EX_MDStart  in  1  single-cycle pulse: a mult/div op is in EX this cycle.
EX_BranchTaken  in  1  a branch or jump resolved taken in EX this cycle.
PCWrite  out  1  PC load enable.
IFIDWrite  out  1  IF/ID load enable.
IFIDFlush  out  1  zero IF/ID on the next edge.
IDEXFlush  out  1  zero ID/EX on the next edge (bubble).
MDBusy  out  1  mult/div result not yet valid.
MDDone  out  1  one-cycle pulse on the cycle the counter reaches 0.
MDOverlapErr  out  1  sticky: EX_MDStart arrived while MDBusy was set.
LoadStallCount  out  STAT_W  load-use stall cycles (optional feature).
MDStallCount  out  STAT_W  HI/LO stall cycles (optional feature).
FlushCount  out  STAT_W  taken-branch flushes (optional feature).

Behaviour:
- Reset (Rst_n=0, asynchronous):
  - MDCount=0, MDDone=0, MDOverlapErr=0, all statistics counters=0.
  - Forced outputs while in reset: PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXFlush=1, MDBusy=0.
  - The first edge after release is normal operation.
- MD counter FSM, states MD_IDLE (MDCount==0) and MD_BUSY (MDCount!=0). Counter width is clog2(MD_LATENCY+1).
  - EX_MDStart in any state: load MDCount=MD_LATENCY and go to MD_BUSY.
  - EX_MDStart while MD_BUSY: also set MDOverlapErr; it clears only on reset.
  - MD_BUSY without EX_MDStart: decrement. On 1->0, MDDone=1 for exactly the following cycle and the FSM enters MD_IDLE.
  - MDBusy = (MDCount!=0), registered.
  - EX_BranchTaken does not affect the counter, because the mult/div op is already past ID/EX.
- Hazard terms (combinational):
  - LoadUse = IDEX_MemRead & (IDEX_Rt!=0) & ((IDEX_Rt==IFID_Rs) | (IFID_UsesRt & IDEX_Rt==IFID_Rt)).
  - MDHaz = MDBusy & IFID_HILOAccess.
- Output priority, highest first:
  1. EX_BranchTaken: PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXFlush=1. Any LoadUse or MDHaz this cycle is ignored, since the ID instruction is discarded.
  2. LoadUse or MDHaz: PCWrite=0, IFIDWrite=0, IFIDFlush=0, IDEXFlush=1 (bubble).
  3. Otherwise: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXFlush=0.
- Stall duration:
  - A load-use stall lasts exactly 1 cycle, since the bubble clears IDEX_MemRead.
  - An MD stall holds until MDBusy falls. The held instruction issues on the cycle MDDone is high.
- Reset asserted mid-stall: the counter clears immediately and forced reset outputs apply.

Optional Feature:
IDEX_HAZARD_STATS_EN
- Defined: three saturating STAT_W counters, updated each non-reset edge.
  - LoadStallCount increments on each priority-2 cycle caused by LoadUse.
  - MDStallCount increments on each priority-2 cycle caused by MDHaz only.
  - FlushCount increments on each priority-1 cycle.
  - Each counter holds at all-ones.
- Undefined: the three outputs are tied to 0 and no counter flops exist.

Test Plan:
- Load then dependent use: IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 -> one cycle of PCWrite=0, IFIDWrite=0, IDEXFlush=1, then normal. Repeat with IDEX_Rt=0 -> no stall.
- rt dependence gating: IDEX_Rt=9, IFID_Rt=9, IFID_UsesRt=0 -> no stall; with IFID_UsesRt=1 -> one-cycle stall.
- Mult then mflo, MD_LATENCY=4: EX_MDStart pulse at cycle 0 with IFID_HILOAccess=1 -> MDBusy high cycles 1-4, stall cycles 1-4, MDDone and issue at cycle 5.
- Branch during stall: LoadUse=1 and EX_BranchTaken=1 in the same cycle -> PCWrite=1, IFIDFlush=1, IDEXFlush=1, no stall.
- Overlap and reset: second EX_MDStart at cycle 2 -> MDCount reloads to 4 and MDOverlapErr=1. Drop Rst_n mid-count -> MDCount=0, MDOverlapErr=0, IFIDFlush=1, IDEXFlush=1 immediately.
- Stats (IDEX_HAZARD_STATS_EN): with STAT_W=2, four flushes -> FlushCount stays at 3.
